// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: collects A, B and opcode bytes from the UART receiver, drives the ALU, and hands the result to the transmitter.
// Opcode rx_done to tx_start takes 2 cycles; bytes arriving while busy are dropped; an inter-byte timeout discards partial frames.
module uart_alu_ctrl #(
    parameter int DBIT    = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 1000000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_done,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic [DBIT-1:0]  i_alu_result,
    input  logic             i_tx_done,
    output logic [DBIT-1:0]  o_alu_a,
    output logic [DBIT-1:0]  o_alu_b,
    output logic [NB_OP-1:0] o_alu_op,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_frame_err
);

    // A one-bit counter is kept when the timeout is disabled so the width never collapses to zero.
    localparam bit            TO_EN    = (TIMEOUT > 0);
    localparam int            CW       = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_EXEC,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [DBIT-1:0]  alu_a_nxt, alu_b_nxt, tx_data_nxt;
    logic [NB_OP-1:0] alu_op_nxt;
    logic             timeout_hit;

    assign timeout_hit = TO_EN && (state == S_B || state == S_OP) && !i_rx_done && (cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_A;
            cnt       <= '0;
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            o_alu_a   <= alu_a_nxt;
            o_alu_b   <= alu_b_nxt;
            o_alu_op  <= alu_op_nxt;
            o_tx_data <= tx_data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        alu_a_nxt   = o_alu_a;
        alu_b_nxt   = o_alu_b;
        alu_op_nxt  = o_alu_op;
        tx_data_nxt = o_tx_data;
        o_frame_err = 1'b0;
        case (state)
            S_A: begin
                if (i_rx_done) begin
                    alu_a_nxt = i_rx_data;
                    cnt_nxt   = '0;
                    state_nxt = S_B;
                end
            end
            S_B: begin
                if (i_rx_done) begin
                    alu_b_nxt = i_rx_data;
                    cnt_nxt   = '0;
                    state_nxt = S_OP;
                end else if (timeout_hit) begin
                    cnt_nxt     = '0;
                    o_frame_err = 1'b1;
                    state_nxt   = S_A;
                end else if (TO_EN) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_OP: begin
                if (i_rx_done) begin
                    alu_op_nxt = i_rx_data[NB_OP-1:0];
                    cnt_nxt    = '0;
                    state_nxt  = S_EXEC;
                end else if (timeout_hit) begin
                    cnt_nxt     = '0;
                    o_frame_err = 1'b1;
                    state_nxt   = S_A;
                end else if (TO_EN) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            // One cycle lets the combinational ALU settle on the freshly registered opcode.
            S_EXEC: begin
                tx_data_nxt = i_alu_result;
                state_nxt   = S_SEND;
            end
            S_SEND: begin
                state_nxt = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_tx_done) begin
                    state_nxt = S_A;
                end
            end
            default: begin
                state_nxt = S_A;
            end
        endcase
    end

    assign o_busy     = (state == S_EXEC) || (state == S_SEND) || (state == S_WAIT_TX);
    assign o_tx_start = (state == S_SEND);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: one instance with TIMEOUT=50, one with the timeout disabled.
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic       rx_done0 = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;

    logic [7:0] alu_a, alu_b, tx_data, alu_res;
    logic [5:0] alu_op;
    logic       tx_start, busy, frame_err;
    logic [7:0] alu_a0, alu_b0, tx_data0, alu_res0;
    logic [5:0] alu_op0;
    logic       tx_start0, busy0, frame_err0;

    int checks = 0;
    int failures = 0;
    int ferr_cnt = 0;
    int ferr0_cnt = 0;
    int start_cnt = 0;
    int npush = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res  = alu(alu_a, alu_b, alu_op);
    assign alu_res0 = alu(alu_a0, alu_b0, alu_op0);

    uart_alu_ctrl #(.DBIT(8), .NB_OP(6), .TIMEOUT(50)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
        .i_alu_result(alu_res), .i_tx_done(tx_done),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy), .o_frame_err(frame_err)
    );

    uart_alu_ctrl #(.DBIT(8), .NB_OP(6), .TIMEOUT(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_rx_done(rx_done0), .i_rx_data(rx_data),
        .i_alu_result(alu_res0), .i_tx_done(tx_done),
        .o_alu_a(alu_a0), .o_alu_b(alu_b0), .o_alu_op(alu_op0),
        .o_tx_start(tx_start0), .o_tx_data(tx_data0), .o_busy(busy0), .o_frame_err(frame_err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every start pulse of the TIMEOUT=50 instance pops one expected result.
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (frame_err0 === 1'b1) ferr0_cnt++;
        if (tx_start === 1'b1) begin
            start_cnt++;
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_tx_start observed=1 expected=0");
            end
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (tx_data === e) else begin
                    failures++;
                    $error("FAIL sb_tx_data observed=0x%0h expected=0x%0h", tx_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] d);
        rx_data = d;
        if (sel) rx_done0 = 1'b1; else rx_done = 1'b1;
        step();
        rx_done  = 1'b0;
        rx_done0 = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(1'b0, a);
        send_byte(1'b0, b);
        exp_q.push_back(alu(a, b, op[5:0]));
        npush++;
        send_byte(1'b0, op);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'd0, tx_start}, 32'd1);
    endtask

    task automatic ack_tx();
        step();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("idle_after_tx_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0;
        step();
        step();
        rst = 1'b0;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_outs", {busy, tx_start, frame_err}, 0);

        // 1: ADD, start pulse exactly two cycles after the opcode byte.
        send_frame(8'h05, 8'h03, 8'h20);
        chk("t1_alu_a", alu_a, 8'h05);
        chk("t1_alu_b", alu_b, 8'h03);
        chk("t1_alu_op", alu_op, 6'h20);
        chk("t1_exec_busy", {busy, tx_start}, 2'b10);
        step();
        chk("t1_start_lat2", {31'd0, tx_start}, 1);
        chk("t1_tx_data", tx_data, 8'h08);
        step();
        chk("t1_start_single", {busy, tx_start}, 2'b10);
        ack_tx();

        // 2: timeout after operand A, then a clean frame resynchronises.
        f0 = ferr_cnt;
        send_byte(1'b0, 8'h11);
        repeat (48) step();
        chk("t2_no_early_err", ferr_cnt, f0);
        step();
        chk("t2_err_cycle50", {31'd0, frame_err}, 1);
        step();
        chk("t2_err_once", ferr_cnt, f0 + 1);
        chk("t2_back_to_idle", {busy, frame_err}, 0);
        chk("t2_a_kept", alu_a, 8'h11);
        send_frame(8'h02, 8'h02, 8'h20);
        wait_start("t2_start_seen");
        chk("t2_tx_data", tx_data, 8'h04);
        ack_tx();

        // 3: byte arrives on the same cycle the counter reaches TIMEOUT-1.
        f0 = ferr_cnt;
        send_byte(1'b0, 8'h33);
        repeat (49) step();
        rx_data = 8'h11;
        rx_done = 1'b1;
        #1;
        chk("t3_no_err_on_tie", {31'd0, frame_err}, 0);
        step();
        rx_done = 1'b0;
        chk("t3_b_accepted", alu_b, 8'h11);
        exp_q.push_back(alu(8'h33, 8'h11, 6'h26));
        npush++;
        send_byte(1'b0, 8'h26);
        wait_start("t3_start_seen");
        chk("t3_tx_data", tx_data, 8'h22);
        chk("t3_no_err", ferr_cnt, f0);
        ack_tx();

        // 4: opcode upper bits dropped; byte received while busy is ignored.
        send_frame(8'h40, 8'h10, 8'hE2);
        chk("t4_op_trunc", alu_op, 6'h22);
        wait_start("t4_start_seen");
        chk("t4_tx_data", tx_data, 8'h30);
        step();
        send_byte(1'b0, 8'h7F);
        chk("t4_a_unchanged", alu_a, 8'h40);
        chk("t4_busy_held", {31'd0, busy}, 1);
        repeat (3) step();
        chk("t4_busy_still", {31'd0, busy}, 1);
        ack_tx();

        // 5: reset in S_SEND and in S_B aborts the frame.
        send_frame(8'h0A, 8'h0B, 8'h24);
        step();
        chk("t5_in_send", {31'd0, tx_start}, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_send_regs", {alu_a, alu_b, 2'b00, alu_op, tx_data}, 0);
        chk("t5_rst_send_outs", {busy, tx_start, frame_err}, 0);
        repeat (4) step();
        chk("t5_no_start_after", start_cnt, npush);
        send_byte(1'b0, 8'h55);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_b_regs", {alu_a, alu_b, 2'b00, alu_op, tx_data}, 0);
        chk("t5_rst_b_outs", {busy, tx_start, frame_err}, 0);
        send_frame(8'h0C, 8'h0A, 8'h25);
        wait_start("t5_start_seen");
        chk("t5_tx_data", tx_data, 8'h0E);
        ack_tx();

        // 6: timeout disabled, long gap between A and B.
        send_byte(1'b1, 8'h09);
        repeat (10000) step();
        chk("t6_still_waiting", {31'd0, busy0}, 0);
        send_byte(1'b1, 8'h04);
        send_byte(1'b1, 8'h22);
        chk("t6_exec", {31'd0, busy0}, 1);
        step();
        chk("t6_start", {31'd0, tx_start0}, 1);
        chk("t6_tx_data", tx_data0, 8'h05);
        chk("t6_no_err", ferr0_cnt, 0);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("t6_idle", {31'd0, busy0}, 0);

        step();
        chk("sb_drained", exp_q.size(), 0);
        chk("start_count", start_cnt, npush);
        chk("total_frame_err", ferr_cnt, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
